// File: rtl/pwm_capture_if.sv
// pwm_capture_if: signal bundle between the PWM capture block and its user.
//   master modport : drives cap_en / pwm_in, observes the measurement status.
//   slave modport  : the capture block itself.
// Signals:
//   cap_en     capture enable; low forces the block idle
//   pwm_in     external PWM waveform, asynchronous to clk
//   period_o   last measured period (rise to rise), clk cycles
//   high_o     last measured high time (rise to fall), clk cycles
//   valid_o    one-cycle pulse when period_o/high_o update
//   timeout_o  level; no edge within 2^WIDTH-1 cycles
//   level_o    synchronized (optionally filtered) input level
interface pwm_capture_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             cap_en;
  logic             pwm_in;
  logic [WIDTH-1:0] period_o;
  logic [WIDTH-1:0] high_o;
  logic             valid_o;
  logic             timeout_o;
  logic             level_o;

  modport master (
    output cap_en,
    output pwm_in,
    input  period_o,
    input  high_o,
    input  valid_o,
    input  timeout_o,
    input  level_o
  );

  modport slave (
    input  cap_en,
    input  pwm_in,
    output period_o,
    output high_o,
    output valid_o,
    output timeout_o,
    output level_o
  );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input in clk cycles.
// The input is synchronized, optionally glitch-filtered, edge-detected and timed with one
// saturating counter. Results are held until the next complete rise-to-rise measurement.
// Ports:
//   clk    peripheral clock
//   rst_n  asynchronous active-low reset
//   bus    pwm_capture_if.slave (cap_en, pwm_in in; period_o, high_o, valid_o, timeout_o,
//          level_o out)
// Build option: define PWM_CAPTURE_FILTER_EN to insert a FILTER_LEN-cycle stability filter
// between the synchronizer and the edge detector.
module pwm_capture #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3
) (
  input logic           clk,
  input logic           rst_n,
  pwm_capture_if.slave  bus
);

  if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_param_check
    $error("pwm_capture: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
  end

  localparam logic [WIDTH-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdle, StArm, StHigh, StLow} state_e;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   lvl;
  logic                   lvl_d;
  logic                   rise;
  logic                   fall;

  state_e           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_inc;
  logic             cnt_sat;
  logic [WIDTH-1:0] high_tmp;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high;
  logic             valid;
  logic             timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], bus.pwm_in};
    end
  end

  assign s = sync[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int unsigned FltW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [FltW-1:0] flt_cnt;
  logic            flt;

  // The filtered level flips only once s has disagreed with it for FILTER_LEN cycles in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt     <= 1'b0;
      flt_cnt <= '0;
    end else if (s != flt) begin
      if (flt_cnt == FltW'(FILTER_LEN - 1)) begin
        flt     <= s;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + FltW'(1);
      end
    end else begin
      flt_cnt <= '0;
    end
  end

  assign lvl = flt;
`else
  assign lvl = s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_d <= 1'b0;
    end else begin
      lvl_d <= lvl;
    end
  end

  assign rise = lvl & ~lvl_d;
  assign fall = ~lvl & lvl_d;

  // cnt+1 sticks at all-ones so a stored value never wraps back to a small number.
  assign cnt_sat = (cnt == CntMax);
  assign cnt_inc = cnt_sat ? cnt : cnt + WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= StIdle;
      cnt      <= '0;
      high_tmp <= '0;
      period   <= '0;
      high     <= '0;
      valid    <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!bus.cap_en) begin
        state   <= StIdle;
        cnt     <= '0;
        timeout <= 1'b0;
      end else begin
        unique case (state)
          StIdle: begin
            cnt   <= '0;
            state <= StArm;
          end
          // Wait for a clean rise; any partial cycle in progress is discarded.
          StArm: begin
            if (rise) begin
              state <= StHigh;
              cnt   <= '0;
            end
          end
          StHigh: begin
            if (fall) begin
              state    <= StLow;
              high_tmp <= cnt_inc;
              cnt      <= cnt_inc;
            end else if (cnt_sat) begin
              state   <= StArm;
              timeout <= 1'b1;
              cnt     <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          StLow: begin
            // A rise coinciding with saturation still measures, but reports all-ones + timeout.
            if (rise) begin
              state   <= StHigh;
              period  <= cnt_inc;
              high    <= high_tmp;
              valid   <= 1'b1;
              timeout <= cnt_sat;
              cnt     <= '0;
            end else if (cnt_sat) begin
              state   <= StArm;
              timeout <= 1'b1;
              cnt     <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
        endcase
      end
    end
  end

  assign bus.period_o  = period;
  assign bus.high_o    = high;
  assign bus.valid_o   = valid;
  assign bus.timeout_o = timeout;
  assign bus.level_o   = lvl;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture. A timestamp-based reference model predicts every
// output each cycle; scenario tasks add fixed expectations for the notable cases.
module tb_pwm_capture;
  localparam int unsigned W    = 8;
  localparam int unsigned SS   = 2;
  localparam int unsigned FL   = 3;
  localparam int          MAXV = (1 << W) - 1;
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FLT_LAT = FL;
`else
  localparam int FLT_LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pwm_capture_if #(.WIDTH(W)) bus ();

  pwm_capture #(
    .WIDTH      (W),
    .SYNC_STAGES(SS),
    .FILTER_LEN (FL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  localparam int MOff = 0, MArm = 1, MRun = 2;

  logic [W-1:0] e_period, e_high;
  logic         e_valid, e_timeout, e_level;
  bit           pin_q[$];
  bit           win_q[$];
  bit           m_lvl, m_lvl_d, m_rise, m_fall, m_in_high, m_s_old, m_nxt, m_flip;
  int           m_mode, m_k, m_t_rise, m_hi_len, m_elapsed;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        pin_q = {};
        repeat (SS) pin_q.push_back(1'b0);
        win_q = {};
        repeat (FL) win_q.push_back(1'b0);
        m_lvl = 0; m_lvl_d = 0; m_mode = MOff; m_in_high = 0;
        m_k = 0; m_t_rise = 0; m_hi_len = 0;
        e_period = '0; e_high = '0; e_valid = 0; e_timeout = 0; e_level = 0;
      end else begin
        m_k++;
        m_rise  = m_lvl & ~m_lvl_d;
        m_fall  = ~m_lvl & m_lvl_d;
        e_valid = 0;
        if (!bus.cap_en) begin
          m_mode    = MOff;
          e_timeout = 0;
        end else if (m_mode == MOff) begin
          m_mode = MArm;
        end else if (m_mode == MArm) begin
          if (m_rise) begin
            m_mode = MRun; m_t_rise = m_k; m_in_high = 1;
          end
        end else begin
          // elapsed = cycles since the measured rise; the counter holds elapsed-1
          m_elapsed = m_k - m_t_rise;
          if (m_in_high && m_fall) begin
            m_in_high = 0;
            m_hi_len  = (m_elapsed > MAXV) ? MAXV : m_elapsed;
          end else if (!m_in_high && m_rise) begin
            e_valid   = 1;
            e_high    = W'(m_hi_len);
            e_period  = (m_elapsed > MAXV) ? W'(MAXV) : W'(m_elapsed);
            e_timeout = (m_elapsed > MAXV);
            m_t_rise  = m_k;
            m_in_high = 1;
          end else if (m_elapsed > MAXV) begin
            m_mode    = MArm;
            e_timeout = 1;
          end
        end
        m_s_old = pin_q[0];
        void'(pin_q.pop_front());
        pin_q.push_back(bus.pwm_in);
`ifdef PWM_CAPTURE_FILTER_EN
        void'(win_q.pop_front());
        win_q.push_back(m_s_old);
        m_flip = 1;
        foreach (win_q[i]) if (win_q[i] == m_lvl) m_flip = 0;
        m_nxt = m_flip ? ~m_lvl : m_lvl;
`else
        m_nxt = pin_q[0];
`endif
        m_lvl_d = m_lvl;
        m_lvl   = m_nxt;
        e_level = m_lvl;
      end
    end
  end

  logic [2*W+2:0] dut_vec, exp_vec;
  assign dut_vec = {bus.period_o, bus.high_o, bus.valid_o, bus.timeout_o, bus.level_o};
  assign exp_vec = {e_period, e_high, e_valid, e_timeout, e_level};

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic settle(input int n);
    bus.cap_en = 1'b0;
    bus.pwm_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int first_hi;
    bus.cap_en = 1'b1;
    bus.pwm_in = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (dut_vec !== '0)
      $display("FAIL reset_values got {p,h,v,t,l}=%h want 0", dut_vec);
    rst_n = 1'b1;
    bus.cap_en = 1'b0;
    first_hi = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_tests++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL reset_model c=%0d got %h want %h", c, dut_vec, exp_vec);
      end
      if (bus.level_o && first_hi < 0) first_hi = c;
    end
    n_tests++;
    if (first_hi !== SS - 1 + FLT_LAT) begin
      n_fail++;
      $display("FAIL sync_latency got %0d want %0d", first_hi, SS - 1 + FLT_LAT);
    end
    bus.pwm_in = 1'b0;
  endtask

  task automatic test_basic();
    int nv = 0;
    settle(8);
    for (int c = 0; c < 70; c++) begin
      bus.cap_en = 1'b1;
      bus.pwm_in = (c % 10) < 3;
      @(negedge clk);
      n_tests++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL basic_model c=%0d got %h want %h", c, dut_vec, exp_vec);
      end
      if (bus.valid_o) begin
        nv++;
        n_tests++;
        if ({bus.period_o, bus.high_o, bus.timeout_o} !== {W'(10), W'(3), 1'b0}) begin
          n_fail++;
          $display("FAIL basic_value got p=%0d h=%0d t=%b want p=10 h=3 t=0",
                   bus.period_o, bus.high_o, bus.timeout_o);
        end
      end
    end
    n_tests++;
    if (nv !== 6) begin
      n_fail++;
      $display("FAIL basic_count got %0d want 6", nv);
    end
  endtask

  task automatic test_duty();
    int nv = 0;
    int exp_h[6] = '{5, 5, 5, 15, 15, 15};
    settle(8);
    for (int c = 0; c < 130; c++) begin
      bus.cap_en = 1'b1;
      bus.pwm_in = (c % 20) < ((c < 60) ? 5 : 15);
      @(negedge clk);
      n_tests++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL duty_model c=%0d got %h want %h", c, dut_vec, exp_vec);
      end
      if (bus.valid_o && nv < 6) begin
        n_tests++;
        if ({bus.period_o, bus.high_o} !== {W'(20), W'(exp_h[nv])}) begin
          n_fail++;
          $display("FAIL duty_value #%0d got p=%0d h=%0d want p=20 h=%0d",
                   nv, bus.period_o, bus.high_o, exp_h[nv]);
        end
      end
      if (bus.valid_o) nv++;
    end
    n_tests++;
    if (nv !== 6) begin
      n_fail++;
      $display("FAIL duty_count got %0d want 6", nv);
    end
  endtask

  task automatic test_timeout();
    int nv = 0, t_to = -1, early = 0;
    settle(8);
    bus.cap_en = 1'b1;
    repeat (4) @(negedge clk);
    for (int c = 0; c < 300; c++) begin
      bus.pwm_in = (c < 4);
      @(negedge clk);
      n_tests++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL timeout_model c=%0d got %h want %h", c, dut_vec, exp_vec);
      end
      if (bus.valid_o) nv++;
      if (bus.timeout_o && t_to < 0) t_to = c;
    end
    // 2 sync + 1 edge-detect cycle, then cnt runs 0..255 before saturating
    n_tests++;
    if (t_to !== 258 + FLT_LAT || nv !== 0) begin
      n_fail++;
      $display("FAIL timeout_time got cyc=%0d valids=%0d want cyc=%0d valids=0",
               t_to, nv, 258 + FLT_LAT);
    end
    nv = 0;
    for (int c = 0; c < 60; c++) begin
      bus.pwm_in = (c % 10) < 4;
      @(negedge clk);
      n_tests++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL resume_model c=%0d got %h want %h", c, dut_vec, exp_vec);
      end
      if (!bus.valid_o && nv == 0 && !bus.timeout_o) early++;
      if (bus.valid_o) begin
        nv++;
        n_tests++;
        if ({bus.period_o, bus.high_o, bus.timeout_o} !== {W'(10), W'(4), 1'b0}) begin
          n_fail++;
          $display("FAIL resume_value got p=%0d h=%0d t=%b want p=10 h=4 t=0",
                   bus.period_o, bus.high_o, bus.timeout_o);
        end
      end
    end
    n_tests++;
    if (nv !== 5 || early !== 0) begin
      n_fail++;
      $display("FAIL resume_count got valids=%0d early_clear=%0d want 5 and 0", nv, early);
    end
  endtask

  task automatic test_enable_drop();
    int nv = 0, drop = 44 + FLT_LAT;
    settle(8);
    for (int c = 0; c < 100; c++) begin
      bus.cap_en = !(c >= drop && c < drop + 3);
      bus.pwm_in = (c % 10) < 3;
      @(negedge clk);
      n_tests++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL drop_model c=%0d got %h want %h", c, dut_vec, exp_vec);
      end
      if (c >= drop && c < drop + 15) begin
        n_tests++;
        if ({bus.period_o, bus.high_o, bus.valid_o} !== {W'(10), W'(3), 1'b0}) begin
          n_fail++;
          $display("FAIL drop_hold c=%0d got p=%0d h=%0d v=%b want p=10 h=3 v=0",
                   c, bus.period_o, bus.high_o, bus.valid_o);
        end
      end
      if (bus.valid_o) nv++;
    end
    n_tests++;
    if (nv !== 8) begin
      n_fail++;
      $display("FAIL drop_count got %0d want 8", nv);
    end
  endtask

  task automatic test_reset_mid();
    int nv_pre = 0, nv_post = 0, rc = 48 + FLT_LAT;
    settle(8);
    for (int c = 0; c < 80; c++) begin
      bus.cap_en = 1'b1;
      bus.pwm_in = (c % 10) < 3;
      if (c == rc) begin
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (dut_vec !== '0) begin
          n_fail++;
          $display("FAIL midreset_values got %h want 0", dut_vec);
        end
      end
      if (c == rc + 2) rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL midreset_model c=%0d got %h want %h", c, dut_vec, exp_vec);
      end
      if (bus.valid_o) begin
        if (c < rc) nv_pre++;
        else nv_post++;
      end
    end
    n_tests++;
    if (nv_pre !== 4 || nv_post !== 2) begin
      n_fail++;
      $display("FAIL midreset_count got pre=%0d post=%0d want 4 and 2", nv_pre, nv_post);
    end
  endtask

  task automatic test_boundary();
    int nv;
    int per[3], hi[3], ep[3], eh[3], et[3], ncyc[3];
    per = '{256, 255, 2 + 2 * FLT_LAT};
    hi  = '{100, 200, 1 + FLT_LAT};
    ep  = '{MAXV, 255, 2 + 2 * FLT_LAT};
    eh  = '{100, 200, 1 + FLT_LAT};
    et  = '{1, 0, 0};
    ncyc = '{530, 530, 60};
    for (int t = 0; t < 3; t++) begin
      nv = 0;
      settle(8);
      for (int c = 0; c < ncyc[t]; c++) begin
        bus.cap_en = 1'b1;
        bus.pwm_in = (c % per[t]) < hi[t];
        @(negedge clk);
        n_tests++;
        if (dut_vec !== exp_vec) begin
          n_fail++;
          $display("FAIL bound%0d_model c=%0d got %h want %h", t, c, dut_vec, exp_vec);
        end
        if (bus.valid_o) begin
          nv++;
          n_tests++;
          if ({bus.period_o, bus.high_o, bus.timeout_o} !==
              {W'(ep[t]), W'(eh[t]), et[t] != 0}) begin
            n_fail++;
            $display("FAIL bound%0d_value got p=%0d h=%0d t=%b want p=%0d h=%0d t=%0d",
                     t, bus.period_o, bus.high_o, bus.timeout_o, ep[t], eh[t], et[t]);
          end
        end
      end
      n_tests++;
      if (nv < 2) begin
        n_fail++;
        $display("FAIL bound%0d_count got %0d want >=2", t, nv);
      end
    end
  endtask

  task automatic test_glitch();
    int nv = 0;
    settle(8);
    for (int c = 0; c < 96; c++) begin
      bus.cap_en = 1'b1;
      bus.pwm_in = ((c % 12) < 6) && ((c % 12) != 2);
      @(negedge clk);
      n_tests++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL glitch_model c=%0d got %h want %h", c, dut_vec, exp_vec);
      end
      if (bus.valid_o) begin
        nv++;
        n_tests++;
`ifdef PWM_CAPTURE_FILTER_EN
        if ({bus.period_o, bus.high_o} !== {W'(12), W'(6)}) begin
          n_fail++;
          $display("FAIL glitch_value got p=%0d h=%0d want p=12 h=6",
                   bus.period_o, bus.high_o);
        end
`else
        // the glitch splits each period into a 3/2 and a 9/3 measurement
        if ({bus.period_o, bus.high_o} !== {W'(3), W'(2)} &&
            {bus.period_o, bus.high_o} !== {W'(9), W'(3)}) begin
          n_fail++;
          $display("FAIL glitch_value got p=%0d h=%0d want 3/2 or 9/3",
                   bus.period_o, bus.high_o);
        end
`endif
      end
    end
    n_tests++;
`ifdef PWM_CAPTURE_FILTER_EN
    if (nv !== 7) begin
      n_fail++;
      $display("FAIL glitch_count got %0d want 7", nv);
    end
`else
    if (nv !== 15) begin
      n_fail++;
      $display("FAIL glitch_count got %0d want 15", nv);
    end
`endif
  endtask

  task automatic test_random();
    int per, hi, len, ph, drop_left;
    bit stuck, lvl;
    settle(8);
    drop_left = 0;
    for (int seg = 0; seg < 30; seg++) begin
      stuck = ($urandom_range(0, 7) == 0);
      per   = $urandom_range(2, 40);
      hi    = $urandom_range(1, per - 1);
      len   = stuck ? $urandom_range(250, 300) : per * $urandom_range(1, 4);
      lvl   = $urandom_range(0, 1) != 0;
      ph    = 0;
      for (int c = 0; c < len; c++) begin
        if (drop_left == 0 && $urandom_range(0, 199) == 0) drop_left = $urandom_range(1, 5);
        bus.cap_en = (drop_left == 0);
        if (drop_left > 0) drop_left--;
        bus.pwm_in = stuck ? lvl : (ph < hi);
        ph = (ph + 1 == per) ? 0 : ph + 1;
        @(negedge clk);
        n_tests++;
        if (dut_vec !== exp_vec) begin
          n_fail++;
          $display("FAIL random_model seg=%0d c=%0d got %h want %h", seg, c, dut_vec, exp_vec);
        end
      end
    end
  endtask

  initial begin
    bus.cap_en = 1'b0;
    bus.pwm_in = 1'b0;
    test_reset();
    test_basic();
    test_duty();
    test_timeout();
    test_enable_drop();
    test_reset_mid();
    test_boundary();
    test_glitch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
